// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state encoding and instruction width.
package prog_loader_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    function automatic logic is_busy(input ld_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
               (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-pair packer: latches the high byte and registers the RAM write port.
import prog_loader_pkg::*;

module prog_loader_packer #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [7:0]         din,
    input  logic [ADDR_W-1:0]  waddr,
    output logic               mem_wren,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_data
);

    logic [7:0] hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_wren <= lo_we;
            if (hi_we) begin
                hi_q <= din;
            end
            // Address and data hold their last value between writes.
            if (lo_we) begin
                mem_addr <= waddr;
                mem_data <= {hi_q, din};
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: framed byte stream in, 16-bit instruction RAM writes out.
import prog_loader_pkg::*;

module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_wren,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_data,
    output logic               core_hold,
    output logic               done,
    output logic               err
);

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [7:0]        sum;
    logic [7:0]        sum_nxt;
    logic [15:0]       len_full;
    logic              too_long;
    logic              accept;
    logic              begin_load;
    logic [ADDR_W-1:0] waddr;

    assign in_ready   = is_busy(state);
    assign accept     = in_valid && in_ready && !abort;
    assign begin_load = !is_busy(state) && start;
    assign len_full   = {len_hi, in_data};
    assign too_long   = 32'(len_full) > (32'd1 << ADDR_W);
    assign idx_inc    = idx + 1'b1;
    assign sum_nxt    = sum + in_data;
    assign waddr      = ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];

    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign core_hold = is_busy(state) || (state == ST_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!is_busy(state)) begin
            if (start) begin
                state_nxt = ST_LEN_HI;
            end
        end else if (abort) begin
            state_nxt = ST_ERR;
        end else if (accept) begin
            unique case (state)
                ST_LEN_HI: state_nxt = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (len_full == 16'd0) begin
                        state_nxt = ST_CSUM;
                    end else if (too_long) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: state_nxt = ST_DATA_LO;
                ST_DATA_LO: begin
                    state_nxt = (idx_inc == n_words) ? ST_CSUM : ST_DATA_HI;
                end
                ST_CSUM: begin
                    state_nxt = (sum_nxt == 8'd0) ? ST_DONE : ST_ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi  <= '0;
            n_words <= '0;
            idx     <= '0;
            sum     <= '0;
        end else if (begin_load) begin
            idx <= '0;
            sum <= '0;
        end else if (accept) begin
            sum <= sum_nxt;
            if (state == ST_LEN_HI) begin
                len_hi <= in_data;
            end
            // Oversized lengths go to ERR, so truncation never matters.
            if (state == ST_LEN_LO) begin
                n_words <= len_full[ADDR_W:0];
            end
            if (state == ST_DATA_LO) begin
                idx <= idx_inc;
            end
        end
    end

    prog_loader_packer #(
        .ADDR_W(ADDR_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .hi_we    (accept && (state == ST_DATA_HI)),
        .lo_we    (accept && (state == ST_DATA_LO)),
        .din      (in_data),
        .waddr    (waddr),
        .mem_wren (mem_wren),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader with a byte-position model.
module tb_prog_loader;

    localparam int AW = 8;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        abort = 0;
    logic        in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready;
    logic        mem_wren;
    logic [AW-1:0] mem_addr;
    logic [15:0] mem_data;
    logic        core_hold;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-position model: 0 idle, 1 busy, 2 done, 3 err
    int         m_mode = 0;
    int         m_pos;
    int         m_n;
    logic [7:0] m_nhi, m_hi, m_sum;
    logic       m_wren = 0;
    logic [AW-1:0] m_addr = 0;
    logic [15:0] m_data = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_wren = 0; m_addr = 0; m_data = 0;
        end else begin
            m_wren = 0;
            if (m_mode != 1) begin
                if (start) begin
                    m_mode = 1; m_pos = 0; m_sum = 0;
                end
            end else if (abort) begin
                m_mode = 3;
            end else if (in_valid) begin
                m_sum = m_sum + in_data;
                if (m_pos == 0) begin
                    m_nhi = in_data;
                end else if (m_pos == 1) begin
                    m_n = {m_nhi, in_data};
                    if (m_n > (1 << AW)) m_mode = 3;
                end else if (m_pos < 2 + 2 * m_n) begin
                    if (m_pos % 2 == 0) begin
                        m_hi = in_data;
                    end else begin
                        m_wren = 1;
                        m_addr = AW'((m_pos - 3) / 2);
                        m_data = {m_hi, in_data};
                    end
                end else begin
                    m_mode = (m_sum == 0) ? 2 : 3;
                end
                m_pos++;
            end
        end
    end

    int dut_wr_cnt = 0;
    logic [AW-1:0] wr_a[$];
    logic [15:0]   wr_d[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_mode == 1);
            check("done", done, m_mode == 2);
            check("err", err, m_mode == 3);
            check("core_hold", core_hold, m_mode == 1 || m_mode == 3);
            check("mem_wren", mem_wren, m_wren);
            check("mem_addr", mem_addr, m_addr);
            check("mem_data", mem_data, m_data);
        end
        if (mem_wren) begin
            dut_wr_cnt++;
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_data);
        end
    end

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 100;
        bit acc = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 0;
            in_data = 8'($urandom);
            start = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        start = 0;
        in_valid = 1;
        in_data = b;
        while (!acc) begin
            @(posedge clk);
            acc = in_ready;
            #1;
            if (!acc) begin
                budget--;
                if (budget == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL byte_accept_timeout: got no accept expected accept");
                    acc = 1;
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) send_byte(q[i], gaps);
    endtask

    function automatic void make_frame(input int n, input bit corrupt,
                                       output logic [7:0] q[$]);
        logic [7:0] s = 0;
        q = {};
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
        foreach (q[i]) s = s + q[i];
        s = 8'(0) - s;
        if (corrupt) s = s + 8'($urandom_range(1, 255));
        q.push_back(s);
    endfunction

    initial begin
        logic [7:0] q[$];
        int base;
        fork
            begin
                #3ms;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_hold", core_hold, 0);
        check("rst_done_err", {done, err}, 0);

        // Test 1: two-word frame, checksum 0x40
        @(posedge clk); #1;
        pulse_start();
        base = dut_wr_cnt;
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_q(q, 0);
        @(negedge clk);
        check("t1_wr_cnt", dut_wr_cnt - base, 2);
        check("t1_a0", wr_a[base], 0);
        check("t1_d0", wr_d[base], 16'h1234);
        check("t1_a1", wr_a[base + 1], 1);
        check("t1_d1", wr_d[base + 1], 16'hABCD);
        check("t1_done", done, 1);
        check("t1_hold", core_hold, 0);

        // Test 2: empty frames
        pulse_start();
        base = dut_wr_cnt;
        q = '{8'h00, 8'h00, 8'h00};
        send_q(q, 0);
        @(negedge clk);
        check("t2_done", done, 1);
        pulse_start();
        q = '{8'h00, 8'h00, 8'h05};
        send_q(q, 0);
        @(negedge clk);
        check("t2_err", err, 1);
        check("t2_hold", core_hold, 1);
        check("t2_nowr", dut_wr_cnt - base, 0);

        // Test 3: length 257 exceeds 2**8 words
        pulse_start();
        base = dut_wr_cnt;
        q = '{8'h01, 8'h01};
        send_q(q, 0);
        @(negedge clk);
        check("t3_err", err, 1);
        check("t3_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_nowr", dut_wr_cnt - base, 0);

        // Test 4: random frames with gaps, incl. max length
        for (int f = 0; f < 6; f++) begin
            int n = (f == 5) ? 256 : $urandom_range(1, 20);
            bit bad = (f % 3 == 2);
            pulse_start();
            base = dut_wr_cnt;
            make_frame(n, bad, q);
            send_q(q, 1);
            @(negedge clk);
            check("t4_wr_cnt", dut_wr_cnt - base, n);
            check("t4_status", {done, err}, bad ? 2'b01 : 2'b10);
            @(posedge clk); #1;
        end

        // Test 5: reset after 3 words of an 8-word load
        pulse_start();
        make_frame(8, 0, q);
        for (int i = 0; i < 8; i++) send_byte(q[i], 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t5_hold", core_hold, 0);
        check("t5_ready", in_ready, 0);
        check("t5_idle", {done, err}, 0);
        pulse_start();
        make_frame(8, 0, q);
        send_q(q, 1);
        @(negedge clk);
        check("t5_done", done, 1);

        // Test 6: abort together with a DATA_LO byte
        pulse_start();
        base = dut_wr_cnt;
        q = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
        send_q(q, 0);
        in_valid = 1; in_data = 8'h44; abort = 1;
        @(posedge clk); #1;
        in_valid = 0; abort = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_wr_cnt", dut_wr_cnt - base, 1);
        check("t6_err", err, 1);
        start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        make_frame(4, 0, q);
        send_q(q, 0);
        @(negedge clk);
        check("t6_done", {done, err}, 2'b10);

        // Random aborts mid-frame
        for (int f = 0; f < 3; f++) begin
            int k;
            pulse_start();
            make_frame(6, 0, q);
            k = $urandom_range(0, 13);
            for (int i = 0; i < k; i++) send_byte(q[i], 1);
            abort = 1;
            @(posedge clk); #1;
            abort = 0;
            @(negedge clk);
            check("abort_err", err, 1);
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
